drum_timing: RTL

//   Drum-rotation timing generator clocked by the periodic bit-time strobe from the

---
 rtl/drum_timing.sv | 119 +++++++++++
 1 files changed

// File: rtl/drum_timing.sv
// Drum-rotation timing generator: bit/word counters stepped by the timer's
// bit-time strobe, plus a run/step FSM that gates the CPU bit enable so
// execution always starts and stops on whole-word boundaries.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   tick         bit-time strobe from the timer (1 clk wide, may be held)
//   run_req      level: request continuous run
//   step_req     pulse: request one word of execution (honoured in IDLE only)
//   bit_time     current bit time, 0..BITS-1
//   word_time    current word time, 0..WORDS-1
//   t0, t_last   decodes of bit_time == 0 / BITS-1
//   word_end     tick on the last bit of a word
//   rev_end      word_end on the last word of the revolution
//   cpu_en       tick gated by the run/step state
//   running      FSM is in RUN
//   step_done    word_end that completes a single-step word
module drum_timing #(
   parameter  int BITS  = 29,
   parameter  int WORDS = 108,
   localparam int BW    = $clog2(BITS),
   localparam int WW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick,
   input  logic          run_req,
   input  logic          step_req,
   output logic [BW-1:0] bit_time,
   output logic [WW-1:0] word_time,
   output logic          t0,
   output logic          t_last,
   output logic          word_end,
   output logic          rev_end,
   output logic          cpu_en,
   output logic          running,
   output logic          step_done
);

   localparam logic [BW-1:0] BIT_LAST  = BW'(BITS - 1);
   localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RUN,
      RUN,
      WAIT_STEP,
      STEP_WORD
   } state_t;

   state_t state;

   // Counters free-run with the drum regardless of the FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_time  <= '0;
         word_time <= '0;
      end else if (tick) begin
         if (bit_time == BIT_LAST) begin
            bit_time <= '0;
            if (word_time == WORD_LAST)
               word_time <= '0;
            else
               word_time <= word_time + 1'b1;
         end else begin
            bit_time <= bit_time + 1'b1;
         end
      end
   end

   assign t0     = (bit_time == '0);
   assign t_last = (bit_time == BIT_LAST);

   // Strobes are suppressed during reset so a reset cycle never looks like
   // the end of a word or the completion of a step.
   assign word_end  = !rst && tick && t_last;
   assign rev_end   = word_end && (word_time == WORD_LAST);
   assign cpu_en    = !rst && tick
                      && ((state == RUN) || (state == STEP_WORD));
   assign step_done = word_end && (state == STEP_WORD);
   assign running   = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (run_req)
                  state <= WAIT_RUN;
               else if (step_req)
                  state <= WAIT_STEP;
            end
            WAIT_RUN: begin
               // Abandoning the request before the word boundary is free.
               if (!run_req)
                  state <= IDLE;
               else if (word_end)
                  state <= RUN;
            end
            RUN: begin
               // A mid-word drop of run_req lets the current word finish.
               if (word_end && !run_req)
                  state <= IDLE;
            end
            WAIT_STEP: begin
               if (word_end)
                  state <= STEP_WORD;
            end
            STEP_WORD: begin
               if (word_end)
                  state <= run_req ? RUN : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
